// File: rtl/pwm_led_pkg.sv
// Shared types and helpers for the PWM fade controller: channel fade state
// and the saturating duty-step arithmetic used by every channel.
package pwm_led_pkg;

    localparam int STEP_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } fade_state_t;

    // Move duty one step toward target, landing exactly on target when the
    // remaining distance is within one step (or the step is zero).
    function automatic int unsigned sat_step(
        input int unsigned duty,
        input int unsigned target,
        input int unsigned step
    );
        int unsigned res;
        res = target;
        if (step != 0) begin
            if (duty < target) begin
                if (target - duty > step) begin
                    res = duty + step;
                end
            end else if (duty > target) begin
                if (duty - target > step) begin
                    res = duty - step;
                end
            end
        end
        return res;
    endfunction

    function automatic fade_state_t fade_dir(
        input int unsigned duty,
        input int unsigned target
    );
        fade_state_t st;
        st = IDLE;
        if (duty < target) begin
            st = UP;
        end else if (duty > target) begin
            st = DOWN;
        end
        return st;
    endfunction

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// Configuration handshake between the front end (master) and the fade
// controller (slave): one channel write per cfg_valid & cfg_ready cycle.
interface pwm_fade_ctrl_if #(
    parameter int NCH = 4,
    parameter int DW  = 8
);
    // One spare index bit so out-of-range channel numbers reach the decoder
    // and are dropped there instead of aliasing onto a real channel.
    localparam int CH_W = $clog2(NCH) + 1;

    logic                          cfg_valid;
    logic                          cfg_ready;
    logic [CH_W-1:0]               cfg_ch;
    logic [DW-1:0]                 cfg_target;
    logic [pwm_led_pkg::STEP_W-1:0] cfg_step;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_target,
        output cfg_step,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_target,
        input  cfg_step,
        output cfg_ready
    );

endinterface

// File: rtl/pwm_fade_channel.sv
// One LED channel: holds duty/target/step and the fade FSM, and produces the
// registered PWM compare output against the shared period counter.
module pwm_fade_channel
    import pwm_led_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wrap,
    input  logic              wr_en,
    input  logic [DW-1:0]     wr_target,
    input  logic [STEP_W-1:0] wr_step,
    input  logic [DW-1:0]     cnt,
    output logic              pwm,
    output logic              busy
);

    logic [DW-1:0]     duty_reg,   duty_next;
    logic [DW-1:0]     target_reg, target_next;
    logic [STEP_W-1:0] step_reg,   step_next;
    fade_state_t       state_reg,  state_next;
    logic              pwm_reg,    pwm_next;
    logic              busy_reg,   busy_next;

    always_comb begin
        duty_next   = duty_reg;
        target_next = target_reg;
        step_next   = step_reg;

        if (wr_en) begin
            target_next = wr_target;
            step_next   = wr_step;
        end

        // Duty only moves on the wrap cycle so every period sees a single,
        // stable compare value from its first tick.
        case (state_reg)
            UP, DOWN: begin
                if (wrap) begin
                    duty_next = DW'(sat_step(32'(duty_reg), 32'(target_reg),
                                             32'(step_reg)));
                end
            end
            default: begin
                duty_next = duty_reg;
            end
        endcase

        state_next = fade_dir(32'(duty_next), 32'(target_next));
        busy_next  = (state_next != IDLE);
        pwm_next   = en && (cnt < duty_reg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_reg   <= '0;
            target_reg <= '0;
            step_reg   <= '0;
            state_reg  <= IDLE;
            pwm_reg    <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            duty_reg   <= duty_next;
            target_reg <= target_next;
            step_reg   <= step_next;
            state_reg  <= state_next;
            pwm_reg    <= pwm_next;
            busy_reg   <= busy_next;
        end
    end

    assign pwm  = pwm_reg;
    assign busy = busy_reg;

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Fade/brightness controller: shared prescaler and PWM period counter, config
// decode, and NCH fading PWM channels driving the LED pins.
module pwm_fade_ctrl
    import pwm_led_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int DW    = 8,
    parameter int PRESC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    pwm_fade_ctrl_if.slave    cfg,
    output logic [NCH-1:0]    pwm_out,
    output logic [NCH-1:0]    busy,
    output logic              period_tick
);

    localparam int CH_W = $clog2(NCH) + 1;
    localparam int PW   = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PW-1:0] presc_reg, presc_next;
    logic [DW-1:0] cnt_reg,   cnt_next;
    logic          tick;
    logic          wrap;
    logic          wr_accept;

    assign tick = en && (presc_reg == PW'(PRESC - 1));
    assign wrap = tick && (cnt_reg == '1);

    always_comb begin
        presc_next = presc_reg;
        cnt_next   = cnt_reg;
        if (!en) begin
            presc_next = '0;
            cnt_next   = '0;
        end else if (tick) begin
            presc_next = '0;
            cnt_next   = cnt_reg + 1'b1;
        end else begin
            presc_next = presc_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            presc_reg <= presc_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Refusing writes on the wrap cycle keeps target updates and duty steps
    // from ever landing on the same edge.
    assign cfg.cfg_ready = ~wrap;
    assign wr_accept     = cfg.cfg_valid && !wrap;
    assign period_tick   = wrap;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic wr_hit;
        assign wr_hit = wr_accept && (cfg.cfg_ch == CH_W'(gi));

        pwm_fade_channel #(
            .DW(DW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .wrap      (wrap),
            .wr_en     (wr_hit),
            .wr_target (cfg.cfg_target),
            .wr_step   (cfg.cfg_step),
            .cnt       (cnt_reg),
            .pwm       (pwm_out[gi]),
            .busy      (busy[gi])
        );
    end

endmodule
